// File: rtl/sha_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// sha_sweep_scheduler
//
// Feeds a super-pipelined SHA round chain with one block per cycle while it
// sweeps a range of nonces. Results come back from the pipeline tail in issue
// order. Each result is matched to its nonce and checked against a
// leading-zero difficulty. Once the pipeline has drained, job completion is
// reported.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   job_valid_i/ready_o job handshake (ready is high exactly while idle)
//   midstate_i          initial hash state for the job
//   block_i             16x32 W template
//   nonce_start_i       first nonce of the sweep
//   nonce_count_i       number of nonces to sweep (0 = empty job)
//   abort_i             stop issuing the current job
//   state_o, W_o        pipeline head data (W_o[NONCE_WORD] carries the nonce)
//   valid_o, newblock_o pipeline head qualifiers
//   digest_i            pipeline tail digest
//   result_valid_i      pipeline tail valid
//   found_valid_o       one-cycle hit pulse, found_nonce_o is its nonce
//   done_o, aborted_o   one-cycle job-retired pulse, aborted_o qualifies it
//   protocol_err_o      sticky: a result arrived with nothing outstanding
// -----------------------------------------------------------------------------
module sha_sweep_scheduler #(
  parameter int LATENCY    = 64,
  parameter int NONCE_WORD = 3,
  parameter int ZERO_BITS  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                job_valid_i,
  output logic                job_ready_o,
  input  logic [255:0]        midstate_i,
  input  logic [15:0][31:0]   block_i,
  input  logic [31:0]         nonce_start_i,
  input  logic [31:0]         nonce_count_i,
  input  logic                abort_i,
  output logic [255:0]        state_o,
  output logic [15:0][31:0]   W_o,
  output logic                valid_o,
  output logic                newblock_o,
  input  logic [255:0]        digest_i,
  input  logic                result_valid_i,
  output logic                found_valid_o,
  output logic [31:0]         found_nonce_o,
  output logic                done_o,
  output logic                aborted_o,
  output logic                protocol_err_o
);

  localparam int OUT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 job_ready_q, job_ready_d;
  logic [255:0]         midstate_q, midstate_d;
  logic [15:0][31:0]    block_q, block_d;
  logic [31:0]          issue_nonce_q, issue_nonce_d;
  logic [31:0]          remaining_q, remaining_d;
  logic [31:0]          ret_nonce_q, ret_nonce_d;
  logic                 first_q, first_d;
  logic                 abort_flag_q, abort_flag_d;
  logic [OUT_W-1:0]     outstanding_q, outstanding_d;
  logic                 valid_q, valid_d;
  logic                 newblock_q, newblock_d;
  logic [255:0]         state_out_q, state_out_d;
  logic [15:0][31:0]    w_out_q, w_out_d;
  logic                 found_valid_q, found_valid_d;
  logic [31:0]          found_nonce_q, found_nonce_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;
  logic                 perr_q, perr_d;

  logic                 accept_s;
  logic                 issue_s;
  logic                 hit_s;
  logic [15:0][31:0]    w_issue_s;

  assign accept_s = (state_q == ST_IDLE) && job_valid_i;
  // A beat goes out on every ISSUE cycle unless abort kills it.
  assign issue_s  = (state_q == ST_ISSUE) && !abort_i;
  assign hit_s    = (digest_i[255 -: ZERO_BITS] == {ZERO_BITS{1'b0}});

  // Template with the current nonce spliced into its fixed word.
  always_comb begin
    w_issue_s             = block_q;
    w_issue_s[NONCE_WORD] = issue_nonce_q;
  end

  // Outstanding beat counter and sticky protocol error.
  always_comb begin
    outstanding_d = outstanding_q;
    perr_d        = perr_q;
    if (result_valid_i && (outstanding_q == {OUT_W{1'b0}})) begin
      // A result with nothing in flight is an integration fault; the counter
      // must not underflow.
      perr_d        = 1'b1;
      outstanding_d = issue_s ? {{(OUT_W-1){1'b0}}, 1'b1} : {OUT_W{1'b0}};
    end else if (issue_s && !result_valid_i) begin
      outstanding_d = outstanding_q + {{(OUT_W-1){1'b0}}, 1'b1};
    end else if (!issue_s && result_valid_i) begin
      outstanding_d = outstanding_q - {{(OUT_W-1){1'b0}}, 1'b1};
    end else begin
      outstanding_d = outstanding_q;
    end
  end

  // Result path: in-order nonce tracking and hit reporting, in every state.
  always_comb begin
    found_valid_d = 1'b0;
    found_nonce_d = found_nonce_q;
    ret_nonce_d   = ret_nonce_q;
    if (accept_s) begin
      ret_nonce_d = nonce_start_i;
    end else if (result_valid_i) begin
      ret_nonce_d = ret_nonce_q + 32'd1;
    end else begin
      ret_nonce_d = ret_nonce_q;
    end
    if (result_valid_i && hit_s) begin
      found_valid_d = 1'b1;
      found_nonce_d = ret_nonce_q;
    end else begin
      found_valid_d = 1'b0;
    end
  end

  // Job FSM: next state plus issue-side registered outputs.
  always_comb begin
    state_d       = state_q;
    midstate_d    = midstate_q;
    block_d       = block_q;
    issue_nonce_d = issue_nonce_q;
    remaining_d   = remaining_q;
    first_d       = first_q;
    abort_flag_d  = abort_flag_q;
    valid_d       = 1'b0;
    newblock_d    = 1'b0;
    state_out_d   = state_out_q;
    w_out_d       = w_out_q;
    done_d        = 1'b0;
    aborted_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (job_valid_i) begin
          midstate_d    = midstate_i;
          block_d       = block_i;
          issue_nonce_d = nonce_start_i;
          remaining_d   = nonce_count_i;
          first_d       = 1'b1;
          abort_flag_d  = 1'b0;
          state_d       = (nonce_count_i == 32'd0) ? ST_DRAIN : ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (abort_i) begin
          abort_flag_d = 1'b1;
          state_d      = ST_DRAIN;
        end else begin
          valid_d       = 1'b1;
          newblock_d    = first_q;
          first_d       = 1'b0;
          state_out_d   = midstate_q;
          w_out_d       = w_issue_s;
          issue_nonce_d = issue_nonce_q + 32'd1;
          remaining_d   = remaining_q - 32'd1;
          state_d       = (remaining_q == 32'd1) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        // done_q high means the pulse is already out; leave on the next edge
        // so job_ready_o rises the cycle after done_o.
        if (done_q) begin
          state_d = ST_IDLE;
        end else if (outstanding_d == {OUT_W{1'b0}}) begin
          done_d    = 1'b1;
          aborted_d = abort_flag_q;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    job_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      job_ready_q   <= 1'b1;
      midstate_q    <= 256'd0;
      block_q       <= {16{32'd0}};
      issue_nonce_q <= 32'd0;
      remaining_q   <= 32'd0;
      ret_nonce_q   <= 32'd0;
      first_q       <= 1'b0;
      abort_flag_q  <= 1'b0;
      outstanding_q <= {OUT_W{1'b0}};
      valid_q       <= 1'b0;
      newblock_q    <= 1'b0;
      state_out_q   <= 256'd0;
      w_out_q       <= {16{32'd0}};
      found_valid_q <= 1'b0;
      found_nonce_q <= 32'd0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      perr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      job_ready_q   <= job_ready_d;
      midstate_q    <= midstate_d;
      block_q       <= block_d;
      issue_nonce_q <= issue_nonce_d;
      remaining_q   <= remaining_d;
      ret_nonce_q   <= ret_nonce_d;
      first_q       <= first_d;
      abort_flag_q  <= abort_flag_d;
      outstanding_q <= outstanding_d;
      valid_q       <= valid_d;
      newblock_q    <= newblock_d;
      state_out_q   <= state_out_d;
      w_out_q       <= w_out_d;
      found_valid_q <= found_valid_d;
      found_nonce_q <= found_nonce_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      perr_q        <= perr_d;
    end
  end

  assign job_ready_o    = job_ready_q;
  assign state_o        = state_out_q;
  assign W_o            = w_out_q;
  assign valid_o        = valid_q;
  assign newblock_o     = newblock_q;
  assign found_valid_o  = found_valid_q;
  assign found_nonce_o  = found_nonce_q;
  assign done_o         = done_q;
  assign aborted_o      = aborted_q;
  assign protocol_err_o = perr_q;

  // Digest bits below the difficulty field do not affect the hit decision.
  logic unused_digest_s;
  assign unused_digest_s = ^digest_i;

endmodule

// File: doc/sha_sweep_scheduler.md
Name: sha_sweep_scheduler

Overview:
- Sequences the super-pipelined SHA round chain for nonce sweeps.
- Accepts a job: midstate, 16-word block template, start nonce and nonce count. Issues one block per cycle into the pipeline head with the nonce written into a fixed W word.
- Matches in-order pipeline results back to their nonces and reports hits against a leading-zero difficulty.
- Reports job completion after the pipeline has drained.

Parameters:
- LATENCY, 64, cycles from pipeline head valid to pipeline tail valid; sizes the outstanding counter.
- NONCE_WORD, 3, index into W[15:0] that is replaced by the nonce.
- ZERO_BITS, 32, number of most significant digest bits that must be zero for a hit (1..256).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- job_valid_i  in  1  job offered.
- job_ready_o  out  1  scheduler idle; job accepted when job_valid_i && job_ready_o.
- midstate_i  in  HashState (256)  initial hash state for the job.
- block_i  in  16x32  W template.
- nonce_start_i  in  32  first nonce.
- nonce_count_i  in  32  number of nonces to sweep.
- abort_i  in  1  stop issuing the current job.
- state_o  out  HashState  to pipeline head.
- W_o  out  16x32  to pipeline head.
- valid_o  out  1  to pipeline head.
- newblock_o  out  1  to pipeline head.
- digest_i  in  256  pipeline tail result.
- result_valid_i  in  1  pipeline tail valid.
- found_valid_o  out  1  one-cycle hit pulse.
- found_nonce_o  out  32  nonce of the hit; valid with found_valid_o.
- done_o  out  1  one-cycle pulse when the job is fully retired.
- aborted_o  out  1  qualifies done_o; 1 if the job ended by abort.
- protocol_err_o  out  1  sticky; set by result_valid_i while outstanding==0.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - valid_o, newblock_o, found_valid_o, done_o, aborted_o and protocol_err_o are 0.
  - state_o, W_o and found_nonce_o are 0.
  - job_ready_o is 1 (it is high exactly in IDLE).
  - All counters are cleared.
- IDLE, on accept:
  - Latch midstate, block and nonce_start into issue_nonce and ret_nonce; latch remaining = nonce_count_i.
  - If nonce_count_i==0: go to DRAIN; done_o pulses on the next cycle with aborted_o=0 and nothing is issued.
  - Otherwise go to ISSUE.
- ISSUE, each cycle:
  - Drive registered outputs: valid_o=1; state_o = latched midstate; W_o = template with W_o[NONCE_WORD] = issue_nonce.
  - newblock_o=1 only on the first issued beat of the job.
  - Then increment issue_nonce (mod 2^32; 0xFFFFFFFF wraps to 0) and decrement remaining.
  - When the last beat issues, go to DRAIN; valid_o is 0 the following cycle.
  - Throughput is 1 nonce per cycle with no bubbles.
- abort_i in ISSUE:
  - The beat in that cycle is not issued; go to DRAIN and set abort_flag.
  - abort_i in IDLE or DRAIN is ignored.
- First issued beat appears on valid_o the cycle after acceptance.
- Outstanding counter:
  - Width clog2(LATENCY+1).
  - +1 on an issue beat, -1 on result_valid_i, unchanged when both occur in the same cycle.
  - result_valid_i at 0 sets protocol_err_o and leaves the counter at 0.
- Result path (active in any state):
  - On result_valid_i, hit = digest_i[255 -: ZERO_BITS]==0.
  - On a hit, next cycle: found_valid_o=1 and found_nonce_o=ret_nonce.
  - ret_nonce increments (mod 2^32) on every result_valid_i, hit or not.
  - Back-to-back hits produce back-to-back pulses.
  - found_nonce_o holds its last value otherwise.
- DRAIN:
  - When outstanding==0 (including the cycle a final decrement reaches 0), pulse done_o for one cycle with aborted_o=abort_flag, then return to IDLE.
  - Hits during DRAIN are reported normally. A hit pulse and done_o may coincide.
- A new job is accepted only in IDLE, so jobs never interleave in the pipeline. job_ready_o rises the cycle after done_o.
- Reset mid-job returns immediately to the reset values above. Pipeline contents are not flushed; a reset of the pipeline valid chain is required by the integrator.

Test Plan:
- Basic sweep: nonce_start=0x10, count=4, pipeline model LATENCY=64.
  - Expect 4 consecutive valid_o beats with W_o[3]=0x10..0x13 and newblock_o only on the first.
  - Expect done_o at tail retirement with aborted_o=0.
- Hit reporting: model returns digest with the top 32 bits zero for the third result.
  - Expect a single found_valid_o with found_nonce_o=0x12.
- Wrap-around: nonce_start=0xFFFFFFFE, count=3.
  - Expect issued nonces 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
  - Forcing hits on all results gives the same three values on found_nonce_o.
- Abort: count=100, abort_i asserted on the 10th issue cycle.
  - Expect exactly 9 beats issued and done_o after 9 results with aborted_o=1.
  - Expect job_ready_o=1 the next cycle.
- Zero count: count=0.
  - Expect no valid_o and done_o one cycle after acceptance.
  - A spurious result_valid_i afterwards sets protocol_err_o=1 and it stays set.
- Asynchronous reset mid-ISSUE (rst low between clock edges).
  - Expect all outputs 0 and job_ready_o=1 immediately.
  - A new job with nonce_start=0x5 issues 0x5 first with newblock_o=1.
